instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  output  32  fetch byte address, bits [1:0] always 2'b00.
REQ-006 Port: imem_rvalid  input  1  imem_rdata valid this cycle; meaningful only while imem_req=1.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: out_valid  output  1  out_instr/out_pc/out_pc_plus4 hold a valid instruction for decode.
REQ-009 Port: out_ready  input  1  decode/execute consumes the instruction this cycle.
REQ-010 Port: out_instr  output  32  instruction word; out_instr[6:0] is the opcode driving the main decoder.
REQ-011 Port: out_pc  output  32  address of out_instr.
REQ-012 Port: out_pc_plus4  output  32  out_pc + 4, mod 2^32.
REQ-013 Port: redirect  input  1  taken branch or jump; next fetch from redirect_target.
REQ-014 Port: redirect_target  input  32  redirect byte address; bits [1:0] ignored (treated as 00).

Function
REQ-015 States SHALL be IDLE, WAIT, HOLD; next-state logic based on current state and inputs only.
REQ-016 IDLE: imem_req=0, out_valid=0; SHALL go to WAIT unconditionally next cycle.
REQ-017 WAIT: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until the cycle imem_rvalid=1.
REQ-018 WAIT with imem_rvalid=1, no kill pending, redirect=0: capture imem_rdata into out_instr, pc into out_pc, go to HOLD.
REQ-019 HOLD: out_valid=1, imem_req=0; out_instr/out_pc/out_pc_plus4 SHALL stay stable while out_ready=0.
REQ-020 HOLD with out_ready=1, redirect=0: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), go to WAIT.
REQ-021 HOLD with redirect=1 (regardless of out_ready): pc <= {redirect_target[31:2],2'b00}, held instruction dropped, go to WAIT.
REQ-022 WAIT with redirect=1 and imem_rvalid=1 same cycle: rdata discarded, pc <= target, stay WAIT, new request at target next cycle.
REQ-023 WAIT with redirect=1 and imem_rvalid=0: store target, set kill; address SHALL NOT change until rvalid.
REQ-024 WAIT with kill set and imem_rvalid=1: rdata discarded, pc <= stored target, kill cleared, stay WAIT.
REQ-025 Second redirect while kill set SHALL overwrite the stored target (last redirect wins).
REQ-026 redirect in IDLE SHALL set pc to target; first request goes to target.
REQ-027 Min latency: request issued cycle N, rvalid in N, out_valid in N+1; next request earliest N+2 (one instruction per two cycles max).

Reset
REQ-028 rst_n=0 at a rising edge SHALL give next cycle: state=IDLE, pc=RESET_PC, kill=0, stored target=0, out_instr=32'h0000_0013 (NOP), out_pc=RESET_PC.
REQ-029 Outputs during/after reset: imem_req=0, out_valid=0, out_pc_plus4=RESET_PC+4.
REQ-030 Reset mid-WAIT or mid-HOLD SHALL abandon the pending fetch/instruction; late imem_rvalid after reset SHALL be ignored (state IDLE).

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN=32, NOP encoding 32'h0000_0013, and the fetch state enum.
REQ-032 One sub-module, fetch_pc_reg: PC register with sync active-low reset, load-enable, next-PC mux (pc+4 / target).
REQ-033 Target 120-400 RTL lines; no combinational path from imem_rdata to any output.

Verification
REQ-034 Reset release, memory responds 1 cycle after req with 32'h0000_0033 -> imem_addr=0, out_valid 2 cycles after release, out_instr=32'h33, out_pc=0, out_pc_plus4=4.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_* stable, imem_req=0; out_ready=1 -> next imem_addr=4.
REQ-036 HOLD, out_pc=32'h10, redirect=1, target=32'h0000_0103 -> next imem_addr=32'h100, held instruction never consumed.
REQ-037 WAIT addr 32'h8, redirect to 32'h40, rvalid 3 cycles later -> imem_addr stays 8 until rvalid, data discarded, then req at 32'h40; out_valid stays 0 throughout.
REQ-038 pc=32'hFFFF_FFFC consumed -> next imem_addr=0, out_pc_plus4 was 0.
REQ-039 rst_n=0 while in WAIT with rvalid asserted -> next cycle out_valid=0, imem_req=0, out_instr=NOP, pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice: word size, NOP encoding,
// fetch FSM states and an address-alignment helper.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: holds the address of the next instruction word to request,
// advancing by one word or jumping to a word-aligned target when loaded.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            sel_target_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = sel_target_i ? word_align(target_i) : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at a time, holds it
// for decode, and handles redirects including ones that race an in-flight request.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] opc_q, opc_d;

  logic            pc_load, pc_sel_tgt;
  logic [XLEN-1:0] pc_tgt, pc;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (pc_load),
    .sel_target_i(pc_sel_tgt),
    .target_i    (pc_tgt),
    .pc_o        (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StWait;
      StWait: if (imem_rvalid && !redirect && !kill_q) state_d = StHold;
      StHold: if (redirect || out_ready) state_d = StWait;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == StWait);
    out_valid = (state_q == StHold);
  end

  // A redirect cannot retarget a request already on the bus, so it is parked
  // in tgt_q and the stale response is dropped when it arrives.
  always_comb begin
    kill_d     = kill_q;
    tgt_d      = tgt_q;
    instr_d    = instr_q;
    opc_d      = opc_q;
    pc_load    = 1'b0;
    pc_sel_tgt = 1'b0;
    pc_tgt     = redirect_target;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_load    = 1'b1;
          pc_sel_tgt = 1'b1;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (redirect) begin
            pc_load    = 1'b1;
            pc_sel_tgt = 1'b1;
          end else if (kill_q) begin
            pc_load    = 1'b1;
            pc_sel_tgt = 1'b1;
            pc_tgt     = tgt_q;
          end else begin
            instr_d = imem_rdata;
            opc_d   = pc;
          end
        end else if (redirect) begin
          tgt_d  = word_align(redirect_target);
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_load    = 1'b1;
          pc_sel_tgt = 1'b1;
        end else if (out_ready) begin
          pc_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill_q  <= 1'b0;
      tgt_q   <= '0;
      instr_q <= NOP;
      opc_q   <= RESET_PC;
    end else begin
      kill_q  <= kill_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  assign imem_addr    = pc;
  assign out_instr    = instr_q;
  assign out_pc       = opc_q;
  assign out_pc_plus4 = opc_q + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory, a queue of expected fetch addresses
// in program order, and a monitor that checks each instruction presented to decode.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid, out_valid, out_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus4, redirect_target;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend;
  int          mem_lat = 0;
  int          pres_cnt = 0;

  logic        mon_prev = 1'b0;
  logic        mon_have = 1'b0;
  logic [31:0] mon_cur = '0;

  logic        m_req_prev = 1'b0;
  int          m_lat = 0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  logic        r_rd, r_rdy;
  logic [31:0] r_tg;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .redirect       (redirect),
    .redirect_target(redirect_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h0000_9E37 + 32'h0000_0033;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of decode-side inputs and record the address the next
  // presented instruction must come from.
  task automatic step(input logic rd, input logic [31:0] tg, input logic rdy);
    redirect        = rd;
    redirect_target = tg;
    out_ready       = rdy;
    if (rst_n) begin
      if (rd) begin
        pend = {tg[31:2], 2'b00};
        if (out_valid || exp_q.size() == 0) exp_q.push_back(pend);
        else exp_q[exp_q.size()-1] = pend;
      end else if (out_valid && rdy) begin
        pend = pend + 32'd4;
        exp_q.push_back(pend);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_out_pc", out_pc, RESET_PC);
    chk("rst_out_pc_plus4", out_pc_plus4, RESET_PC + 32'd4);
    exp_q.delete();
    pend = RESET_PC;
    exp_q.push_back(pend);
    rst_n = 1'b1;
  endtask

  // Instruction memory with per-request latency; garbage on rdata when not valid.
  initial begin : memory
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        if (!m_req_prev || imem_rvalid) begin
          m_lat  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
          m_cnt  = 0;
          m_addr = imem_addr;
        end else begin
          m_cnt++;
          chk("addr_stable", imem_addr, m_addr);
        end
        chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
        imem_rvalid = (m_cnt >= m_lat);
        imem_rdata  = imem_rvalid ? mem_word(imem_addr) : $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      m_req_prev = (imem_req === 1'b1);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (!mon_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL present: got instruction at pc %h expected none", out_pc);
            mon_have = 1'b0;
          end else begin
            mon_cur  = exp_q.pop_front();
            mon_have = 1'b1;
            pres_cnt++;
          end
        end
        if (mon_have) begin
          chk("out_pc", out_pc, mon_cur);
          chk("out_instr", out_instr, mem_word(mon_cur));
          chk("out_pc_plus4", out_pc_plus4, mon_cur + 32'd4);
        end
      end
      mon_prev = (out_valid === 1'b1);
    end
  end

  initial begin : main
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    out_ready       = 1'b0;
    pend            = RESET_PC;
    do_reset();

    // First fetch after reset release, zero-latency memory.
    step(1'b0, 32'h0, 1'b0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    step(1'b0, 32'h0, 1'b0);
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_instr", out_instr, 32'h0000_0033);
    chk("first_pc", out_pc, 32'h0);
    chk("first_pc4", out_pc_plus4, 32'h4);

    // Stall decode: held outputs are checked by the monitor every cycle.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      step(1'b0, 32'h0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("next_addr_4", imem_addr, 32'h4);
    step(1'b0, 32'h0, 1'b0);
    mem_lat = 3;
    step(1'b0, 32'h0, 1'b1);

    // Redirect races a slow request to 0x8.
    chk("slow_addr_8", imem_addr, 32'h8);
    step(1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("kill_addr_8", imem_addr, 32'h8);
      chk("kill_no_valid", {31'b0, out_valid}, 32'd0);
      if (i == 2) mem_lat = 0;
      step(1'b0, 32'h0, 1'b0);
    end
    chk("kill_addr_40", imem_addr, 32'h40);
    chk("kill_req_40", {31'b0, imem_req}, 32'd1);
    chk("kill_valid_40", {31'b0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b0);

    // Redirect out of HOLD drops the held instruction.
    step(1'b1, 32'h10, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("hold_pc_10", out_pc, 32'h10);
    step(1'b1, 32'h103, 1'b0);
    chk("redir_addr_100", imem_addr, 32'h100);
    step(1'b0, 32'h0, 1'b0);

    // Wrap from the last word of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("wrap_pc4", out_pc_plus4, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_addr_0", imem_addr, 32'h0);

    // Reset while a response is arriving.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    do_reset();
    step(1'b0, 32'h0, 1'b0);
    chk("post_rst_addr", imem_addr, RESET_PC);

    // Randomized traffic with variable memory latency.
    mem_lat = -1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        r_rd  = ($urandom_range(0, 7) == 0);
        r_tg  = $urandom;
        if ($urandom_range(0, 3) == 0) r_tg = 32'hFFFF_FFF0 | {28'b0, r_tg[3:0]};
        r_rdy = ($urandom_range(0, 2) != 0);
        step(r_rd, r_tg, r_rdy);
      end
    end
    chk("enough_presentations", {31'b0, pres_cnt > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
